// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 access codes,
// the FSM state type and the access legality rule.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when funct3 is legal for the access direction and the byte offset
  // is naturally aligned for the access size. Range is checked separately.
  function automatic logic access_legal(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !we && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Word-organised data array with per-byte write enables, synchronous write
// and combinational (asynchronous) read of the same word address.
module byte_en_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes; unselected lanes keep their contents.
  // NOTE: the array has no reset -- contents are undefined until written,
  // which keeps it mappable onto RAM macros. Sequential state uses <= so all
  // flops update from pre-edge values.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a byte-enabled word array. Accepts one request
// via valid/ready, waits LATENCY cycles, performs the access, then pulses a
// one-cycle response. Illegal, misaligned and out-of-range accesses are
// rejected with resp_err and never write.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 64,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;

  logic        accept, access_fire, err, in_range;
  logic [1:0]  off;
  logic [3:0]  be, ram_we;
  logic [31:0] wlanes, rd_word, shifted, load_val;

  assign accept      = req_valid && req_ready;
  assign access_fire = (state == BUSY) && (cnt == 4'd0);
  assign off         = addr_q[1:0];
  assign in_range    = (addr_q[31:2+AW] == '0);
  assign err         = !access_legal(we_q, funct3_q, off) || !in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = BUSY;
      BUSY:    if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = accept ? BUSY : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: ready everywhere except while the access is pending.
  always_comb begin
    req_ready  = (state != BUSY);
    resp_valid = (state == RESP);
  end

  // Request capture, latency countdown and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        cnt      <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access_fire) begin
        resp_err   <= err;
        resp_rdata <= (err || we_q) ? '0 : load_val;
      end
    end
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << off;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Reset wins over a coinciding access edge: the pending store is dropped.
  assign ram_we = (access_fire && we_q && !err && !rst) ? be : 4'b0000;

  byte_en_ram #(
    .DEPTH (ADDR_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[2 +: AW]),
    .wdata (wlanes),
    .rdata (rd_word)
  );

  // Load extract: bring the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    shifted  = rd_word >> {off, 3'b000};
    load_val = '0;
    case (funct3_q)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_val = {24'h0, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_val = {16'h0, shifted[15:0]};
      F3_W:    load_val = shifted;
      default: load_val = '0;
    endcase
  end

endmodule
